// File: rtl/s2axi_pkg.sv
// Shared constants, FSM state type and a constant log2 helper
// for the stream-to-AXI ring writer.
package s2axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/s2axi_ring_writer_if.sv
// AXI3 write-side bundle (AW, W, B) between the ring writer and
// the memory slave.
interface s2axi_ring_writer_if #(
    parameter int DW = 32
);
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sfifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy level
// and a single-cycle flush.
module sfifo_fwft
    import s2axi_pkg::*;
#(
    parameter int DW = 32,
    parameter int DEPTH = 64,
    localparam int AW = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;

    assign level = wp_q - rp_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem_q[rp_q[AW-1:0]];

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (push && !full) wp_d = wp_q + 1'b1;
            if (pop && !empty) rp_d = rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem_q[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/s2axi_ring_writer.sv
// Packs a sample stream into fixed-length INCR bursts and writes
// them round-robin into a DDR ring buffer.
module s2axi_ring_writer
    import s2axi_pkg::*;
#(
    parameter int DW         = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_OUT    = 4
) (
    input  logic          AXI_clk,
    input  logic          rst,
    input  logic          sync,
    input  logic [DW-1:0] Sin,
    input  logic          Ien,
    input  logic [31:0]   ibase,
    input  logic [17:0]   isize,
    output logic [17:0]   iacnt,
    output logic [31:0]   ibcnt,
    output logic          ovf,
    output logic          err,
    s2axi_ring_writer_if.master AXI
);
    localparam int          FAW    = clog2(FIFO_DEPTH);
    localparam logic [3:0]  LAST   = 4'(BURST_LEN - 1);
    localparam logic [31:0] STRIDE = 32'(BURST_LEN * DW / 8);

    state_e        state_q, state_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    out_q, out_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          wlast_q, wlast_d;
    logic [17:0]   iacnt_q, iacnt_d;
    logic [31:0]   ibcnt_q, ibcnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;

    logic [FAW:0]  lvl;
    logic [DW-1:0] head;
    logic          full, empty, push, pop, flush;
    logic          aw_hs, w_hs, b_ok, restart, can_issue;

    assign aw_hs   = awvalid_q & AXI.awready;
    assign w_hs    = wvalid_q & AXI.wready;
    assign b_ok    = AXI.bvalid && (AXI.bresp == AXI_RESP_OKAY);
    assign restart = pend_q && (state_q == IDLE) && (out_q == '0);
    assign push    = Ien && !pend_q;
    assign pop     = w_hs && !empty;
    assign flush   = restart;

    assign can_issue = (lvl >= (FAW+1)'(BURST_LEN))
                    && (out_q < 4'(MAX_OUT))
                    && (isize != '0)
                    && !pend_q && !sync;

    sfifo_fwft #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (AXI_clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (Sin),
        .pop   (pop),
        .dout  (head),
        .level (lvl),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        awaddr_d = awaddr_q;
        unique case (state_q)
            IDLE: if (can_issue) begin
                state_d  = ADDR;
                awaddr_d = ibase + 32'(iacnt_q) * STRIDE;
            end
            ADDR: if (aw_hs) begin
                state_d = DATA;
                beat_d  = '0;
            end
            DATA: if (w_hs) begin
                if (beat_q == LAST) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        awvalid_d = (state_d == ADDR);
        wvalid_d  = (state_d == DATA);
        wlast_d   = (state_d == DATA) && (beat_d == LAST);
    end

    // A shrunken isize takes effect here: any index past the end wraps.
    always_comb begin
        out_d   = out_q;
        iacnt_d = iacnt_q;
        ibcnt_d = ibcnt_q;
        ovf_d   = ovf_q | (push & full);
        err_d   = err_q | (AXI.bvalid & ~b_ok);
        pend_d  = pend_q | sync;
        if (aw_hs && !AXI.bvalid) out_d = out_q + 4'd1;
        if (!aw_hs && AXI.bvalid) out_d = out_q - 4'd1;
        if (aw_hs) begin
            if (({1'b0, iacnt_q} + 19'd1) >= {1'b0, isize}) iacnt_d = '0;
            else iacnt_d = iacnt_q + 18'd1;
        end
        if (b_ok) ibcnt_d = ibcnt_q + 32'd1;
        if (restart) begin
            iacnt_d = '0;
            ibcnt_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            pend_d  = sync;
        end
    end

    always_ff @(posedge AXI_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            out_q     <= '0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            iacnt_q   <= '0;
            ibcnt_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            iacnt_q   <= iacnt_d;
            ibcnt_q   <= ibcnt_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
        end
    end

    assign AXI.awaddr  = awaddr_q;
    assign AXI.awlen   = LAST;
    assign AXI.awsize  = 3'(clog2(DW / 8));
    assign AXI.awburst = AXI_BURST_INCR;
    assign AXI.awvalid = awvalid_q;
    assign AXI.wdata   = head;
    assign AXI.wstrb   = '1;
    assign AXI.wlast   = wlast_q;
    assign AXI.wvalid  = wvalid_q;
    assign AXI.bready  = 1'b1;

    assign iacnt = iacnt_q;
    assign ibcnt = ibcnt_q;
    assign ovf   = ovf_q;
    assign err   = err_q;
endmodule

// File: tb/tb_s2axi_ring_writer.sv
// Randomized bench for s2axi_ring_writer: a queue-based model of the
// accepted sample stream, ring addressing and response bookkeeping.
module tb_s2axi_ring_writer;
    import s2axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s2axi_ring_writer_if #(.DW(32)) ifa ();
    s2axi_ring_writer_if #(.DW(64)) ifb ();

    logic        sync_a = 1'b0, ien_a = 1'b0, ovf_a, err_a;
    logic [31:0] sin_a = '0, ibcnt_a;
    logic [31:0] ibase_a = 32'h1000_0000;
    logic [17:0] isize_a = 18'd4, iacnt_a;

    logic        sync_b = 1'b0, ien_b = 1'b0, ovf_b, err_b;
    logic [63:0] sin_b = '0;
    logic [31:0] ibcnt_b;
    logic [31:0] ibase_b = 32'h2000_0000;
    logic [17:0] isize_b = 18'd1000, iacnt_b;

    s2axi_ring_writer #(
        .DW(32), .BURST_LEN(16), .FIFO_DEPTH(64), .MAX_OUT(4)
    ) u_a (
        .AXI_clk(clk), .rst(rst), .sync(sync_a), .Sin(sin_a),
        .Ien(ien_a), .ibase(ibase_a), .isize(isize_a),
        .iacnt(iacnt_a), .ibcnt(ibcnt_a), .ovf(ovf_a), .err(err_a),
        .AXI(ifa)
    );

    s2axi_ring_writer #(
        .DW(64), .BURST_LEN(8), .FIFO_DEPTH(32), .MAX_OUT(2)
    ) u_b (
        .AXI_clk(clk), .rst(rst), .sync(sync_b), .Sin(sin_b),
        .Ien(ien_b), .ibase(ibase_b), .isize(isize_b),
        .iacnt(iacnt_b), .ibcnt(ibcnt_b), .ovf(ovf_b), .err(err_b),
        .AXI(ifb)
    );

    int n_vec = 0, n_bad = 0, cyc = 0;
    int aw1 = 0, aw2 = 0;
    // model of instance A
    logic [31:0] dq[$];
    int nburst = 0, beat_a = 0, bpend_a = 0, nresp_a = 0, ibcnt_m = 0;
    bit err_m = 0, ovf_m = 0, sync_req = 0;
    int ien_left_a = 0, bad_idx = -1;
    int p_ien = 100, p_awr = 100, p_wr = 100, p_bv = 100, p_bad = 0;
    // instance B slave state
    int ien_left_b = 0, aw_b = 0, bpend_b = 0, b_allow = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit          full_m;
        logic [31:0] exp_d;
        logic [31:0] exp_a;
        @(negedge clk);
        cyc++;
        full_m = (dq.size() >= 64);
        sync_a = sync_req;
        sync_req = 0;
        ien_a = (ien_left_a > 0) && ($urandom_range(99) < p_ien);
        if (ien_a) ien_left_a--;
        sin_a = $urandom;
        ifa.awready = ($urandom_range(99) < p_awr);
        ifa.wready  = ($urandom_range(99) < p_wr);
        ifa.bvalid  = (bpend_a > 0) && ($urandom_range(99) < p_bv);
        ifa.bresp   = 2'b00;
        if (ifa.bvalid && (nresp_a == bad_idx || $urandom_range(99) < p_bad))
            ifa.bresp = 2'b10;
        if (ifa.awvalid && ifa.awready) begin
            exp_a = ibase_a + 32'(nburst % int'(isize_a)) * 32'd64;
            chk("a_awaddr", ifa.awaddr, exp_a);
            chk("a_awlen", ifa.awlen, 15);
            chk("a_awsize", ifa.awsize, 2);
            if (nburst == 0 && aw1 == 0) aw1 = cyc;
            if (nburst == 1 && aw2 == 0) aw2 = cyc;
            nburst++;
        end
        if (ifa.wvalid && ifa.wready) begin
            exp_d = 'x;
            if (dq.size() > 0) exp_d = dq.pop_front();
            chk("a_wdata", ifa.wdata, exp_d);
            chk("a_wlast", ifa.wlast, beat_a == 15);
            beat_a = (beat_a + 1) % 16;
            if (beat_a == 0) bpend_a++;
        end
        if (ifa.bvalid) begin
            bpend_a--;
            nresp_a++;
            if (ifa.bresp == 2'b00) ibcnt_m++;
            else err_m = 1;
        end
        if (ien_a) begin
            if (full_m) ovf_m = 1;
            else dq.push_back(sin_a);
        end

        ien_b = (ien_left_b > 0);
        if (ien_b) ien_left_b--;
        sin_b = {$urandom, $urandom};
        ifb.awready = 1'b1;
        ifb.wready  = 1'b1;
        ifb.bvalid  = (bpend_b > 0) && (b_allow > 0);
        ifb.bresp   = 2'b00;
        if (ifb.awvalid && ifb.awready) begin
            chk("b_awaddr", ifb.awaddr, ibase_b + 32'(aw_b) * 32'h40);
            chk("b_awsize", ifb.awsize, 3);
            chk("b_awlen", ifb.awlen, 7);
            chk("b_awburst", ifb.awburst, 1);
            aw_b++;
        end
        if (ifb.wvalid && ifb.wready && ifb.wlast) bpend_b++;
        if (ifb.bvalid) begin
            bpend_b--;
            b_allow--;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_a();
        chk("a_iacnt", iacnt_a, 64'(nburst % int'(isize_a)));
        chk("a_ibcnt", ibcnt_a, 64'(ibcnt_m));
        chk("a_ovf", ovf_a, ovf_m);
        chk("a_err", err_a, err_m);
    endtask

    initial begin
        ifa.awready = 0; ifa.wready = 0; ifa.bvalid = 0; ifa.bresp = 0;
        ifb.awready = 0; ifb.wready = 0; ifb.bvalid = 0; ifb.bresp = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_awvalid", ifa.awvalid, 0);
        chk("rst_wvalid", ifa.wvalid, 0);
        chk("rst_wlast", ifa.wlast, 0);
        chk("rst_awaddr", ifa.awaddr, 0);
        check_a();

        // 64 samples: four bursts round the ring, back to index 0
        ien_left_a = 64;
        run(120);
        chk("aw_latency", aw1, 18);
        chk("aw_period", aw2 - aw1, 18);
        chk("a_bursts4", nburst, 4);
        check_a();

        // 16 more: fifth burst wraps to the base
        ien_left_a = 16;
        run(60);
        chk("a_bursts5", nburst, 5);
        check_a();

        // overflow with the W channel stalled
        p_wr = 0;
        ien_left_a = 70;
        run(75);
        chk("a_level_full", u_a.lvl, dq.size());
        check_a();
        sync_req = 1;
        p_wr = 100;
        run(100);
        dq.delete();
        nburst = 0; ibcnt_m = 0; err_m = 0; ovf_m = 0;
        chk("a_level_flush", u_a.lvl, 0);
        check_a();

        // error response on the second burst
        bad_idx = nresp_a + 1;
        ien_left_a = 32;
        run(80);
        chk("a_err_ibcnt", ibcnt_a, 1);
        check_a();
        ien_left_a = 32;
        run(80);
        check_a();

        // randomized traffic with stalls and sporadic errors
        p_ien = 70; p_awr = 60; p_wr = 70; p_bv = 50; p_bad = 5;
        ien_left_a = 1500;
        run(1600);
        p_awr = 100; p_wr = 100; p_bv = 100; p_bad = 0;
        run(200);
        check_a();

        // wide config: outstanding limit, then release two responses
        ien_left_b = 40;
        run(60);
        chk("b_aw_max", aw_b, 2);
        chk("b_awvalid_hold", ifb.awvalid, 0);
        b_allow = 2;
        run(40);
        chk("b_aw_after2", aw_b, 4);
        b_allow = 100;
        run(60);
        chk("b_aw_total", aw_b, 5);
        chk("b_ibcnt", ibcnt_b, 5);
        chk("b_iacnt", iacnt_b, 5);

        // reset in the middle of a stalled burst
        p_wr = 0;
        ien_left_a = 20;
        run(25);
        chk("a_midburst", ifa.wvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_awvalid", ifa.awvalid, 0);
        chk("mrst_wvalid", ifa.wvalid, 0);
        chk("mrst_wlast", ifa.wlast, 0);
        chk("mrst_awaddr", ifa.awaddr, 0);
        chk("mrst_iacnt", iacnt_a, 0);
        chk("mrst_ibcnt", ibcnt_a, 0);
        chk("mrst_ovf", ovf_a, 0);
        chk("mrst_err", err_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/s2axi_ring_writer.md
# s2axi_ring_writer

Single-clock, parametrised stream-to-AXI3 write engine. It packs a continuous sample stream into fixed-length INCR bursts and writes them into a circular buffer in DDR, with back-to-back bursts and multiple outstanding write responses. Overflow and write-response errors are reported as sticky flags. It sits beside the AXI read path inside the stream/AXI bridge and replaces the fixed 32-bit, 16-beat write side.

## Interface
- DW, 32: stream and AXI data width in bits; allowed values 32 or 64.
- BURST_LEN, 16: beats per burst, 2..16 (AXI3 limit).
- FIFO_DEPTH, 64: sample FIFO depth; power of 2, at least 2*BURST_LEN.
- MAX_OUT, 4: maximum outstanding bursts awaiting B response, 1..15.
- AXI_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- sync  in  1  one-cycle restart request; clears counters and FIFO.
- Sin  in  DW  stream sample.
- Ien  in  1  Sin valid; no backpressure.
- ibase  in  32  ring base address; aligned to BURST_LEN*DW/8.
- isize  in  18  ring size in bursts; 0 disables the engine.
- iacnt  out  18  index of the next burst to issue within the ring.
- ibcnt  out  32  total bursts completed with OKAY; wraps modulo 2^32.
- ovf  out  1  sticky: a sample was dropped because the FIFO was full.
- err  out  1  sticky: a non-OKAY bresp was received.
- AXI_awaddr  out  32; AXI_awlen  out  4  (BURST_LEN-1); AXI_awsize  out  3  (log2(DW/8)); AXI_awburst  out  2  (INCR); AXI_awvalid  out  1; AXI_awready  in  1.
- AXI_wdata  out  DW; AXI_wstrb  out  DW/8  (all ones); AXI_wlast  out  1; AXI_wvalid  out  1; AXI_wready  in  1.
- AXI_bresp  in  2; AXI_bvalid  in  1; AXI_bready  out  1  (constant 1).

## Operation
- Ien with FIFO not full: Sin is pushed. Ien with FIFO full: the sample is dropped and ovf is set.
- FSM states: IDLE, ADDR, DATA.
- IDLE -> ADDR when all of the following hold: FIFO level >= BURST_LEN, outstanding < MAX_OUT, isize != 0, and no sync is pending.
  - On entry to ADDR, the engine loads AXI_awaddr = ibase + iacnt*BURST_LEN*DW/8. Address arithmetic is 32-bit and wraps modulo 2^32.
- ADDR: AXI_awvalid is held high until AXI_awready. On the AW handshake:
  - outstanding increments.
  - iacnt advances; when iacnt == isize-1 it wraps to 0.
  - The FSM moves to DATA.
- DATA: AXI_wvalid is held high and AXI_wdata is driven from the FIFO head (first-word-fall-through). The FIFO pops on each W handshake.
  - AXI_wlast is high on beat BURST_LEN-1.
  - After the last handshake, the FSM goes to IDLE.
- B channel, on AXI_bvalid:
  - outstanding decrements.
  - If bresp == OKAY, ibcnt increments; otherwise err is set.
  - If an AW handshake and a bvalid occur in the same cycle, outstanding is unchanged.
- sync:
  - Sets a pending flag. While the flag is pending, Ien is ignored.
  - The restart executes when the FSM is in IDLE and outstanding == 0. It flushes the FIFO and clears iacnt, ibcnt, ovf, err and the pending flag, all in one cycle.
  - An in-flight burst always completes first.
- isize changed while running: the new value takes effect at the next wrap check. If iacnt >= isize, iacnt wraps to 0 on the next issue.

## Timing
- Reset values: AXI_awvalid=0, AXI_wvalid=0, AXI_wlast=0, AXI_awaddr=0, iacnt=0, ibcnt=0, ovf=0, err=0, FIFO empty, outstanding=0, FSM in IDLE.
- All AXI outputs are registered.
- AXI_awvalid rises 1 cycle after the FIFO level reaches BURST_LEN while the FSM is in IDLE.
- The first AXI_wvalid occurs in the cycle after the AW handshake.
- Steady-state throughput is BURST_LEN beats per BURST_LEN+2 cycles when awready and wready are held high.
- ibcnt updates in the cycle after the bvalid beat.
- Reset asserted mid-burst: all outputs return to their reset values immediately. The slave side is reset together with the engine.

## Structure
- Package s2axi_pkg holds the shared constants and types:
  - AXI_BURST_INCR = 2'b01.
  - AXI_RESP_OKAY = 2'b00.
  - The state enum {IDLE, ADDR, DATA}.
  - A function clog2 used for awsize and the FIFO pointers.
- Sub-module sfifo_fwft (parameters DW and DEPTH; outputs level, full and empty) instantiates the sample FIFO.

## Test plan
- DW=32, BURST_LEN=16, ibase=0x1000_0000, isize=4: stream 64 samples with Ien held high and awready/wready/bvalid always ready. Required: four bursts at 0x1000_0000, 0x1000_0040, 0x1000_0080, 0x1000_00C0; ibcnt=4; iacnt=0.
- Same configuration, 80 samples. Required: the fifth burst wraps to 0x1000_0000 and iacnt=1.
- MAX_OUT=2 with bvalid withheld: required exactly two AW handshakes, then awvalid stays low. After releasing two bvalids, the third burst issues.
- wready held low while Ien streams 70 samples: required ovf=1 after FIFO_DEPTH pushes and the FIFO level holds at 64. A subsequent sync clears ovf, iacnt and ibcnt.
- bresp=2'b10 on the second burst: required err=1 and ibcnt=1 after the second response, and streaming continues.
- DW=64, BURST_LEN=8: required awsize=3, awlen=7, and address stride 0x40 between bursts.
